// File: rtl/piso_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_serial_tx_pkg
// Purpose  : Shared FSM encodings and counter sizing for the PISO transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package piso_serial_tx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-counter width; guarded so a degenerate WIDTH never yields a zero-width vector.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_core.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_core
// Purpose  : Parallel-load, MSB-first left-shift register with bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module piso_shift_core
  import piso_serial_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             msb_o,
  output logic             last_o
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;

  // Load wins over shift so a back-to-back reload restarts the count cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      shift_q <= din_i;
      cnt_q   <= '0;
    end else if (shift_i) begin
      shift_q <= {shift_q[WIDTH-2:0], 1'b0};
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  assign msb_o  = shift_q[WIDTH-1];
  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_serial_tx
// Purpose  : PISO serial transmitter with one-entry holding buffer and FSM.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en_i,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic             done_q, done_d;
  logic             core_load, core_shift, hold_clr;
  logic             core_msb, core_last;
  logic             xfer;

  // Handshake is independent of the bit tick.
  assign xfer = load_valid_i && !hold_full_q;

  always_comb begin
    state_d    = state_q;
    core_load  = 1'b0;
    core_shift = 1'b0;
    hold_clr   = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clk_en_i && hold_full_q) begin
          core_load = 1'b1;
          hold_clr  = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (clk_en_i) begin
          if (!core_last) begin
            core_shift = 1'b1;
          end else begin
            done_d = 1'b1;
            if (hold_full_q) begin
              core_load = 1'b1;
              hold_clr  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      // xfer needs an empty buffer and hold_clr a full one, so they never coincide.
      if (xfer) begin
        hold_q      <= load_data_i;
        hold_full_q <= 1'b1;
      end else if (hold_clr) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (core_load),
    .shift_i (core_shift),
    .din_i   (hold_q),
    .msb_o   (core_msb),
    .last_o  (core_last)
  );

  assign ser_valid_o  = (state_q == ST_SHIFT);
  assign ser_out_o    = ser_valid_o && core_msb;
  assign busy_o       = ser_valid_o || hold_full_q;
  assign load_ready_o = !hold_full_q;
  assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serial_tx
// Purpose  : Randomised and directed self-checking bench for piso_serial_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serial_tx;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_en;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready, ser_out, ser_valid, busy, done;

  piso_serial_tx #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en_i     (clk_en),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .ser_out_o    (ser_out),
    .ser_valid_o  (ser_valid),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a word queue plus the frame in flight, indexed by bit position.
  logic             m_hold_full;
  logic [WIDTH-1:0] m_hold;
  logic             m_active;
  logic [WIDTH-1:0] m_word;
  int               m_idx;
  logic             m_done;
  logic             m_accepted;
  logic [WIDTH-1:0] sent_q[$];

  // Receiving shift register fed by the DUT's line.
  logic [WIDTH-1:0] rx_sr;
  int               rx_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold_full = 1'b0; m_hold = '0; m_active = 1'b0; m_word = '0;
    m_idx = 0; m_done = 1'b0; m_accepted = 1'b0;
    rx_sr = '0; rx_cnt = 0;
    sent_q.delete();
  endtask

  task automatic model_edge(input logic en, input logic lv, input logic [WIDTH-1:0] d);
    logic xfer;
    logic clr;
    xfer = lv && !m_hold_full;
    clr  = 1'b0;
    m_done = 1'b0;
    if (en) begin
      if (!m_active) begin
        if (m_hold_full) begin
          m_active = 1'b1; m_word = m_hold; m_idx = 0; clr = 1'b1;
        end
      end else if (m_idx < WIDTH - 1) begin
        m_idx++;
      end else begin
        m_done = 1'b1;
        if (m_hold_full) begin
          m_word = m_hold; m_idx = 0; clr = 1'b1;
        end else begin
          m_active = 1'b0;
        end
      end
    end
    if (clr) m_hold_full = 1'b0;
    m_accepted = xfer;
    if (xfer) begin
      m_hold = d; m_hold_full = 1'b1; sent_q.push_back(d);
    end
  endtask

  task automatic check_outputs();
    check_eq("ser_valid",  {31'b0, ser_valid},  {31'b0, m_active});
    check_eq("ser_out",    {31'b0, ser_out},
             {31'b0, m_active ? m_word[WIDTH-1-m_idx] : 1'b0});
    check_eq("busy",       {31'b0, busy},       {31'b0, m_active || m_hold_full});
    check_eq("load_ready", {31'b0, load_ready}, {31'b0, !m_hold_full});
    check_eq("done",       {31'b0, done},       {31'b0, m_done});
  endtask

  // One clock: check at the falling edge, drive, let the rising edge happen, update model.
  task automatic step(input logic en, input logic lv, input logic [WIDTH-1:0] d);
    check_outputs();
    clk_en = en; load_valid = lv; load_data = d;
    if (en && ser_valid) begin
      rx_sr = {rx_sr[WIDTH-2:0], ser_out};
      rx_cnt++;
      if (rx_cnt == WIDTH) begin
        if (sent_q.size() == 0) check_eq("rx_extra", {28'b0, rx_sr}, 32'hFFFF_FFFF);
        else check_eq("rx_word", {28'b0, rx_sr}, {28'b0, sent_q.pop_front()});
        rx_cnt = 0;
      end
    end
    @(posedge clk);
    model_edge(en, lv, d);
    @(negedge clk);
  endtask

  // Hold a word on the bus until accepted; en_period sets the tick rate.
  task automatic offer(input logic [WIDTH-1:0] w, input int en_period, inout int phase);
    int guard;
    guard = 0;
    do begin
      step((phase % en_period) == 0, 1'b1, w);
      phase++; guard++;
    end while (!m_accepted && guard < 60);
    if (!m_accepted) check_eq("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input int en_period, inout int phase);
    for (int i = 0; i < n; i++) begin
      step((phase % en_period) == 0, 1'b0, '0);
      phase++;
    end
  endtask

  task automatic async_reset_check();
    rst = 1'b1;
    #1;
    check_eq("rst_ser_valid",  {31'b0, ser_valid},  32'd0);
    check_eq("rst_ser_out",    {31'b0, ser_out},    32'd0);
    check_eq("rst_busy",       {31'b0, busy},       32'd0);
    check_eq("rst_done",       {31'b0, done},       32'd0);
    check_eq("rst_load_ready", {31'b0, load_ready}, 32'd1);
    model_reset();
    clk_en = 1'b1; load_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ph;
    int done_cnt;
    rst = 1'b1; clk_en = 1'b0; load_valid = 1'b0; load_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    async_reset_check();
    idle(3, 1, ph);

    // Single frame, tick every cycle.
    ph = 0;
    offer(4'b1011, 1, ph);
    idle(7, 1, ph);

    // Slow tick, every third cycle.
    ph = 0;
    offer(4'b0110, 3, ph);
    idle(18, 3, ph);

    // Back-to-back frames; count done pulses in the meantime.
    ph = 0;
    offer(4'hA, 1, ph);
    offer(4'h5, 1, ph);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_done) done_cnt++;
      step(1'b1, 1'b0, '0);
    end
    check_eq("b2b_done_pulses", done_cnt, 32'd2);

    // Backpressure: third word must wait for the buffer to drain.
    ph = 0;
    offer(4'hA, 2, ph);
    offer(4'h5, 2, ph);
    offer(4'hC, 2, ph);
    idle(30, 2, ph);

    // Abort mid-frame, then a clean frame.
    ph = 0;
    offer(4'h9, 1, ph);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    async_reset_check();
    idle(2, 1, ph);
    offer(4'h3, 1, ph);
    idle(7, 1, ph);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
    end
    idle(12, 1, ph);
    check_eq("queue_drained", sent_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_serial_tx.md
# piso_serial_tx

Parallel-in, serial-out transmitter that sends WIDTH-bit words one bit per clock-enable tick, MSB first. It is the transmit end of the lab's serial link. Its `ser_out`/`ser_valid` pair drives the serial input and enable of the receiving shift register directly. After WIDTH ticks the receiver holds the original word. A one-entry holding buffer with a valid/ready handshake lets the next word queue during a frame, so frames go out back-to-back with no idle tick.

## Interface
- WIDTH, 4, word length in bits; legal values are WIDTH ≥ 2.
- clk  in  1  system clock. All state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high. Clears all state.
- clk_en  in  1  bit tick. The transmitter shifts only on edges where clk_en=1.
- load_valid  in  1  a word is offered on load_data.
- load_data  in  WIDTH  word to transmit.
- load_ready  out  1  the holding buffer is empty.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out carries a frame bit. Connects to the receiver's enable.
- busy  out  1  a frame is in progress or a word is queued.
- done  out  1  one-clk pulse after the last bit of a frame is sampled.

## Operation
- Storage:
  - hold_reg[WIDTH-1:0] with hold_full.
  - shift_reg[WIDTH-1:0].
  - bit_cnt, width $clog2(WIDTH).
  - FSM with states IDLE and SHIFT.
- Handshake:
  - A transfer occurs on a clk edge with load_valid && load_ready. It is not gated by clk_en.
  - On a transfer, hold_reg ← load_data and hold_full ← 1.
  - load_ready = !hold_full, a registered-state decode.
  - Holding load_valid while load_ready=0 has no effect; the word is not lost, it is accepted later.
- IDLE:
  - On a clk_en edge with hold_full=1: shift_reg ← hold_reg, hold_full ← 0, bit_cnt ← 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, on a clk_en edge:
  - If bit_cnt < WIDTH-1: shift_reg ← {shift_reg[WIDTH-2:0], 1'b0}, bit_cnt++.
  - If bit_cnt = WIDTH-1 (frame end), done ← 1 for one clk, and then:
    - if hold_full: reload shift_reg from hold_reg, clear hold_full, bit_cnt ← 0, stay in SHIFT;
    - else go to IDLE.
- SHIFT with clk_en=0: all state holds.
- Outputs:
  - ser_out = shift_reg[WIDTH-1] while in SHIFT; 0 in IDLE.
  - ser_valid = (state == SHIFT).
  - busy = (state == SHIFT) || hold_full.
- A transfer into an empty hold_reg in the same cycle the FSM empties it cannot happen, because load_ready is 0 that cycle.
- Reset values: state IDLE, hold_full 0, shift_reg 0, bit_cnt 0. Outputs: ser_out 0, ser_valid 0, busy 0, done 0, load_ready 1.
- Reset mid-frame aborts the frame. ser_valid falls asynchronously and no done pulse is issued.

## Timing
- Latency from transfer to the first bit on the line is the first clk_en edge after the transfer edge.
- Each bit is stable from one clk_en edge to the next. The receiver samples it on the next clk_en edge where ser_valid=1.
- A frame spans exactly WIDTH clk_en edges with ser_valid=1.
- done is registered. It is high for exactly one clk after the WIDTH-th sampling edge, regardless of clk_en.
- In back-to-back mode ser_valid stays high continuously across frames.
- Throughput is one word per WIDTH ticks.

## Structure
- A shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the counter-width function/macro for $clog2(WIDTH).
- One sub-module, `piso_shift_core`:
  - a parallel-load, left-shift register with its bit counter;
  - inputs load, shift, din; outputs msb, last.
- The top level holds the handshake buffer and the FSM.

## Test plan
All scenarios use WIDTH=4.
- Reset: assert rst mid-simulation → all outputs 0 immediately and load_ready=1. Release → state unchanged until a transfer.
- Single frame, clk_en every cycle: load 4'b1011 → ser_valid high 4 cycles with ser_out 1,0,1,1. done pulses once. A paired WIDTH=4 receiver shift register reads 4'b1011.
- Slow tick, clk_en every 3rd cycle: load 4'b0110 → each bit held 3 clks, ser_valid continuous for 12 clks. Receiver reads 4'b0110. done pulses once for 1 clk.
- Back-to-back: load 4'hA, then 4'h5 during the first frame → 8 consecutive valid ticks with bits 1,0,1,0,0,1,0,1. Two done pulses. load_ready low from the 4'h5 transfer until its reload. Receiver reads 4'hA and then 4'h5.
- Backpressure: offer 4'hC while hold_full=1 with load_valid held → not accepted until load_ready rises. Then transmitted intact after the queued word.
- Reset mid-frame: assert rst after 2 bits of 4'h9 → ser_valid drops, no done pulse. Next word 4'h3 is transmitted correctly from its MSB.
